// File: rtl/ibex_imem_pkg.sv
// Shared types and helpers for the instruction-memory responder: response beat,
// stall-LFSR constants and the RAM window decode.
package ibex_imem_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

  // 33-bit compare so a window ending at 4 GiB does not wrap
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [32:0] win_bytes);
    logic [32:0] lim;
    lim = {1'b0, base} + win_bytes;
    return (addr >= base) && ({1'b0, addr} < lim) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ibex_imem_resp_pipe.sv
// RESP_LATENCY-deep response delay line; stage 1 merges the RAM read data that
// arrives one cycle after the grant. No backpressure: one beat in, one beat out.
module ibex_imem_resp_pipe
  import ibex_imem_pkg::*;
#(
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        err_i,
  input  logic [31:0] ram_rdata_i,
  output resp_t       resp_o
);

  logic  s1_vld_q;
  logic  s1_err_q;
  resp_t s1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
      s1_err_q <= 1'b0;
    end else begin
      s1_vld_q <= push_i;
      s1_err_q <= push_i & err_i;
    end
  end

  // Data is only passed for good responses, so idle and error beats read as zero
  always_comb begin
    s1       = '0;
    s1.valid = s1_vld_q;
    s1.err   = s1_err_q;
    s1.rdata = (s1_vld_q && !s1_err_q) ? ram_rdata_i : 32'h0;
  end

  generate
    if (RESP_LATENCY <= 1) begin : g_lat1
      assign resp_o = s1;
    end else begin : g_latn
      resp_t pipe_q [RESP_LATENCY-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < int'(RESP_LATENCY) - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= s1;
          for (int i = 1; i < int'(RESP_LATENCY) - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign resp_o = pipe_q[RESP_LATENCY-2];
    end
  endgenerate

endmodule

// File: rtl/ibex_imem_responder.sv
// Instruction-bus memory responder: grant after GNT_WAIT (+0..3 random with IBEX_IMEM_RAND_STALL_EN),
// rvalid RESP_LATENCY cycles after gnt, at most MAX_OUTSTANDING in flight; sticky initiator-violation flag.
module ibex_imem_responder
  import ibex_imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 4096,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  output logic                         ram_req_o,
  output logic [$clog2(MEM_WORDS)-1:0] ram_addr_o,
  input  logic [31:0]                  ram_rdata_i,
  output logic                         busy_o,
  output logic                         proto_err_o
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int          WW        = $clog2(GNT_WAIT + 5);
  localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) * 33'd4;

  logic [WW-1:0] wait_q, wait_d, thr;
  logic [OW-1:0] out_q, out_d;
  logic          pend_q;
  logic [31:0]   addr_q;
  logic          proto_q;
  logic          gnt;
  logic          dec_ok;
  logic          viol;
  resp_t         resp;

`ifdef IBEX_IMEM_RAND_STALL_EN
  logic [15:0] lfsr_q;
  logic [1:0]  extra_q;
  logic [1:0]  extra;
  logic        new_req;

  // The draw is taken on the first cycle of a request and held until it is granted
  assign new_req = instr_req_i & ~pend_q;
  assign extra   = new_req ? lfsr_q[1:0] : extra_q;
  assign thr     = WW'(GNT_WAIT) + WW'(extra);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q  <= LFSR_SEED;
      extra_q <= 2'd0;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
      if (new_req) extra_q <= lfsr_q[1:0];
    end
  end
`else
  assign thr = WW'(GNT_WAIT);
`endif

  assign gnt    = instr_req_i & ~rst_i & (wait_q >= thr) & (out_q < OW'(MAX_OUTSTANDING));
  assign dec_ok = addr_ok(instr_addr_i, BASE_ADDR, WIN_BYTES);

  // Saturating, so a request parked on a full pipeline keeps its threshold met
  always_comb begin
    wait_d = wait_q;
    if (!instr_req_i || gnt) begin
      wait_d = '0;
    end else if (wait_q != {WW{1'b1}}) begin
      wait_d = wait_q + WW'(1);
    end
  end

  assign out_d = out_q + OW'(gnt) - OW'(resp.valid);

  // A request still pending from last cycle must keep req high and addr stable
  assign viol = pend_q & (~instr_req_i | (instr_addr_i != addr_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q  <= '0;
      out_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= 32'h0;
      proto_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      out_q   <= out_d;
      pend_q  <= instr_req_i & ~gnt;
      addr_q  <= instr_addr_i;
      proto_q <= proto_q | viol;
    end
  end

  ibex_imem_resp_pipe #(
    .RESP_LATENCY (RESP_LATENCY)
  ) u_resp_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (gnt),
    .err_i       (~dec_ok),
    .ram_rdata_i (ram_rdata_i),
    .resp_o      (resp)
  );

  // BASE_ADDR is window-aligned, so the word offset is just the low address bits
  assign ram_req_o      = gnt & dec_ok;
  assign ram_addr_o     = ram_req_o ? instr_addr_i[AW+1:2] : '0;
  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = resp.valid;
  assign instr_err_o    = resp.err;
  assign instr_rdata_o  = resp.rdata;
  assign busy_o         = (out_q != '0);
  assign proto_err_o    = proto_q;

endmodule

// File: doc/ibex_imem_responder.md
Name: ibex_imem_responder

Overview:
- Instruction-bus responder (memory side) of the core's fetch interface: accepts req/addr, issues gnt, returns rvalid/rdata/err.
- Sits between the prefetch path and a single-port synchronous on-chip RAM (MAX10 M9K/M20K), with configurable grant wait states and fixed response latency.
- Serves as the production IMEM front end and as the bench's bus model; includes a protocol checker for initiator violations.

Parameters:
- MEM_WORDS, 4096, RAM depth in 32-bit words (power of 2).
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window (MEM_WORDS*4 aligned).
- GNT_WAIT, 0, wait cycles between req assertion and gnt (0 = same-cycle gnt).
- RESP_LATENCY, 1, cycles from gnt to rvalid (>=1).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- instr_req_i  in  1  request
- instr_addr_i  in  32  byte address, held stable until gnt
- instr_gnt_o  out  1  grant (address phase accepted)
- instr_rvalid_o  out  1  response valid, one cycle per granted request
- instr_rdata_o  out  32  read data
- instr_err_o  out  1  response error, qualified by rvalid
- ram_req_o  out  1  RAM read enable
- ram_addr_o  out  $clog2(MEM_WORDS)  RAM word address
- ram_rdata_i  in  32  RAM data, valid the cycle after ram_req_o
- busy_o  out  1  outstanding count != 0
- proto_err_o  out  1  sticky initiator protocol violation

Behaviour:
- Reset: all outputs 0, wait counter 0, outstanding 0, pipeline empty, proto_err_o cleared. Reset mid-operation drops in-flight responses; no rvalid is issued for them.
- Wait counter wait_q increments each cycle req is high and gnt is low. It clears on gnt or when req is low.
- gnt = req & (wait_q >= GNT_WAIT) & (outstanding_q < MAX_OUTSTANDING). With GNT_WAIT=0 and free space, gnt is combinational in the same cycle as req.
- Address decode on gnt: in range = BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS, and addr[1:0]==0.
  - In range: ram_req_o=1, ram_addr_o=addr offset[..:2].
  - Out of range or misaligned: no RAM access; response marked err.
- Response pipeline: RESP_LATENCY stages of {valid, err, data}. Stage 1 captures ram_rdata_i, or 0 on err.
  - rvalid_o asserts exactly RESP_LATENCY cycles after gnt, responses in order.
  - rdata_o = 0 and err_o = 1 for error responses.
  - rvalid_o=0 implies err_o=0 and rdata_o=0.
- Back-to-back gnts every cycle are allowed while space permits; full throughput when MAX_OUTSTANDING >= RESP_LATENCY+1.
- Outstanding count:
  - +1 on gnt, -1 on rvalid; unchanged when both occur in the same cycle.
  - Width is $clog2(MAX_OUTSTANDING+1).
  - The limit is strict: no gnt at count==MAX, even if rvalid fires that cycle.
- No rvalid backpressure; the initiator must always accept responses.
- Protocol checker sets proto_err_o (sticky until reset) when either occurs:
  - req falls without gnt;
  - addr changes while req is high and ungranted.
  - Violations never alter the response stream.

Optional Feature:
- Macro IBEX_IMEM_RAND_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, advanced each cycle) draws 0-3 extra wait cycles, latched at the first cycle of each new request. The gnt threshold becomes GNT_WAIT + extra. Used to stress the fetch path.
- Undefined: LFSR is absent; grant timing is exactly deterministic as above.

Decomposition:
- Package ibex_imem_pkg:
  - resp_t struct {valid, err, rdata[31:0]};
  - LFSR polynomial/seed constants;
  - addr-in-range function.
- Sub-module ibex_imem_resp_pipe: parameterized RESP_LATENCY delay line of resp_t with RAM-data capture at stage 1. Top level holds the gnt FSM/counters, decode and protocol checker.

Test Plan:
- Defaults; RAM[0..3]=11,22,33,44; req held, addr 0,4,8,C on consecutive gnts.
  - Expect gnt every cycle after the first.
  - Expect rvalid each cycle one after its gnt with rdata 11,22,33,44 and err=0.
- GNT_WAIT=2, single req at addr 0x10.
  - Expect gnt in the 3rd cycle of req.
  - Expect rvalid exactly RESP_LATENCY cycles later; busy_o high for 1 cycle.
- Addresses 0x4000 (MEM_WORDS=4096, out of range) and 0x6 (misaligned).
  - Expect both granted, each with rvalid and err=1, rdata=0.
  - Expect no ram_req_o pulse.
- RESP_LATENCY=3, MAX_OUTSTANDING=2, continuous req.
  - Expect gnt pattern 1,1,0,0,1,1,...
  - Expect outstanding never exceeds 2 and in-order rdata.
- Initiator drops req without gnt (GNT_WAIT=3), then changes addr while waiting in a second request.
  - Expect proto_err_o set after the first violation, staying 1 until rst_i.
- Assert rst_i with 2 responses in flight.
  - Expect no rvalid afterwards and all outputs 0.
  - Expect a new request after reset served normally.
